// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and constants for the parametrised UART transceiver.
package uart_pkg;
    typedef enum int {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
endpackage

// File: rtl/uart_trx_param_if.sv
// uart_trx_param_if: parallel-side TX handshake and RX delivery signals of the UART.
interface uart_trx_param_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;
    modport master (
        output tx_data, tx_valid, rx_ack,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
    modport slave (
        input  tx_data, tx_valid, rx_ack,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider giving one 16x oversample tick every CLK_DIV clocks.
module uart_baud_tick #(
    parameter int CLK_DIV = 54
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign tick = cnt_q == LAST;
endmodule

// File: rtl/uart_trx_param.sv
// uart_trx_param: full-duplex UART with configurable width/parity/stop bits,
// valid/ready TX, error-flagged RX and internal loopback.
module uart_trx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 54,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_trx_param_if.slave        bus,
    output logic                   tx_serial,
    output logic                   tx_active,
    output logic                   tx_done,
    input  logic                   rx_serial,
    input  logic                   loopback
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SMP_MID = 4'(MID_SAMPLE);
    localparam bit ODD = PARITY == PAR_ODD;
    localparam bit HAS_PAR = (PARITY == PAR_EVEN) || ODD;

    logic tick;
    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (.clk(clk), .reset(reset), .tick(tick));

    state_e               tx_st_q, tx_st_d;
    logic [3:0]           tx_smp_q, tx_smp_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_ser_q, tx_ser_d;
    logic                 tx_rdy_q, tx_rdy_d;
    logic                 tx_act_q, tx_act_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_end;

    // tx_act_q doubles as "start bit launched": the bit timer only runs once the line has dropped.
    assign tx_end = tick && tx_act_q && tx_smp_q == SMP_LAST;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_smp_d  = (tick && tx_act_q) ? tx_smp_q + 4'd1 : tx_smp_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_par_d  = tx_par_q;
        tx_ser_d  = tx_ser_q;
        tx_rdy_d  = tx_rdy_q;
        tx_act_d  = tx_act_q;
        tx_done_d = 1'b0;
        case (tx_st_q)
            ST_IDLE: if (bus.tx_valid && tx_rdy_q) begin
                tx_st_d  = ST_START;
                tx_rdy_d = 1'b0;
                tx_sh_d  = bus.tx_data;
                tx_par_d = ^bus.tx_data ^ ODD;
                tx_bit_d = '0;
            end
            ST_START: if (tick && !tx_act_q) begin
                tx_act_d = 1'b1;
                tx_ser_d = 1'b0;
            end else if (tx_end) begin
                tx_st_d  = ST_DATA;
                tx_ser_d = tx_sh_q[0];
            end
            ST_DATA: if (tx_end) begin
                if (tx_bit_q == BIT_LAST) begin
                    tx_st_d  = HAS_PAR ? ST_PARITY : ST_STOP;
                    tx_ser_d = HAS_PAR ? tx_par_q : 1'b1;
                    tx_bit_d = '0;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_ser_d = tx_sh_q[1];
                end
            end
            ST_PARITY: if (tx_end) begin
                tx_st_d  = ST_STOP;
                tx_ser_d = 1'b1;
            end
            ST_STOP: if (tx_end) begin
                if (tx_bit_q == STOP_LAST) begin
                    tx_st_d   = ST_IDLE;
                    tx_act_d  = 1'b0;
                    tx_rdy_d  = 1'b1;
                    tx_done_d = 1'b1;
                end else tx_bit_d = tx_bit_q + 1'b1;
            end
            default: tx_st_d = ST_IDLE;
        endcase
    end

    logic                 sync1_q, sync1_d, sync2_q;
    state_e               rx_st_q, rx_st_d;
    logic [3:0]           rx_smp_q, rx_smp_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_pbad_q, rx_pbad_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_pend_q, rx_pend_d;
    logic                 rx_samp;

    assign sync1_d = loopback ? tx_ser_q : rx_serial;
    assign rx_samp = tick && rx_smp_q == SMP_LAST;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_smp_d   = tick ? rx_smp_q + 4'd1 : rx_smp_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_pbad_d  = rx_pbad_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        rx_ovr_d   = bus.rx_ack ? 1'b0 : rx_ovr_q;
        rx_pend_d  = bus.rx_ack ? 1'b0 : rx_pend_q;
        case (rx_st_q)
            ST_IDLE: begin
                rx_smp_d = '0;
                if (tick && !sync2_q) rx_st_d = ST_START;
            end
            ST_START: if (tick && rx_smp_q == SMP_MID) begin
                rx_smp_d  = '0;
                rx_st_d   = sync2_q ? ST_IDLE : ST_DATA;
                rx_bit_d  = '0;
                rx_par_d  = 1'b0;
                rx_pbad_d = 1'b0;
            end
            ST_DATA: if (rx_samp) begin
                rx_sh_d  = {sync2_q, rx_sh_q[DATA_BITS-1:1]};
                rx_par_d = rx_par_q ^ sync2_q;
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == BIT_LAST) rx_st_d = HAS_PAR ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (rx_samp) begin
                rx_pbad_d = sync2_q ^ rx_par_q ^ ODD;
                rx_st_d   = ST_STOP;
            end
            // Only the first stop bit is checked; returning to IDLE here re-arms RX mid-stop.
            ST_STOP: if (rx_samp) begin
                rx_st_d    = ST_IDLE;
                rx_data_d  = rx_sh_q;
                rx_ferr_d  = !sync2_q;
                rx_perr_d  = rx_pbad_q;
                rx_valid_d = 1'b1;
                rx_pend_d  = 1'b1;
                if (rx_pend_q && !bus.rx_ack) rx_ovr_d = 1'b1;
            end
            default: rx_st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st_q    <= ST_IDLE;
            tx_smp_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_ser_q   <= 1'b1;
            tx_rdy_q   <= 1'b1;
            tx_act_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_st_q    <= ST_IDLE;
            rx_smp_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_pbad_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_pend_q  <= 1'b0;
        end else begin
            tx_st_q    <= tx_st_d;
            tx_smp_q   <= tx_smp_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_ser_q   <= tx_ser_d;
            tx_rdy_q   <= tx_rdy_d;
            tx_act_q   <= tx_act_d;
            tx_done_q  <= tx_done_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync1_q;
            rx_st_q    <= rx_st_d;
            rx_smp_q   <= rx_smp_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_pbad_q  <= rx_pbad_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_pend_q  <= rx_pend_d;
        end
    end

    assign tx_serial         = tx_ser_q;
    assign tx_active         = tx_act_q;
    assign tx_done           = tx_done_q;
    assign bus.tx_ready      = tx_rdy_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_trx_param.sv
// tb_uart_trx_param: directed checks of two UART configurations (8N1 and 7O1) at CLK_DIV=4,
// so one bit lasts 64 clocks.
module tb_uart_trx_param;
    logic clk = 1'b0;
    logic reset, rx_line, lb_a, lb_b;
    logic txs_a, act_a, done_a, txs_b, act_b, done_b;
    int tests = 0, fails = 0, va = 0, vb = 0, da = 0;
    int va0, da0;

    always #5 clk = ~clk;

    uart_trx_param_if #(.DATA_BITS(8)) ifa ();
    uart_trx_param_if #(.DATA_BITS(7)) ifb ();

    uart_trx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave), .tx_serial(txs_a), .tx_active(act_a),
        .tx_done(done_a), .rx_serial(rx_line), .loopback(lb_a)
    );
    uart_trx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave), .tx_serial(txs_b), .tx_active(act_b),
        .tx_done(done_b), .rx_serial(rx_line), .loopback(lb_b)
    );

    always @(posedge clk) begin
        if (ifa.rx_valid) va <= va + 1;
        if (ifb.rx_valid) vb <= vb + 1;
        if (done_a) da <= da + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input bit b, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = (b ? txs_b : txs_a) == 1'b0;
        end
        chk(b ? "tx_start_b" : "tx_start_a", 32'(seen), 1);
    endtask

    task automatic tx_bits(input bit b, input logic [31:0] exp, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            repeat (32) @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, i), 32'(b ? txs_b : txs_a), 32'(exp[i]));
            chk($sformatf("%s_rdy%0d", tag, i), 32'(b ? ifb.tx_ready : ifa.tx_ready), 0);
            chk($sformatf("%s_act%0d", tag, i), 32'(b ? act_b : act_a), 1);
            repeat (32) @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line = bits[i];
            repeat (64) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic ack(input bit b);
        @(negedge clk);
        if (b) ifb.rx_ack = 1'b1; else ifa.rx_ack = 1'b1;
        @(negedge clk);
        ifa.rx_ack = 1'b0;
        ifb.rx_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0; rx_line = 1'b1; lb_a = 1'b1; lb_b = 1'b1;
        ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.rx_ack = 1'b0;
        ifb.tx_data = '0; ifb.tx_valid = 1'b0; ifb.rx_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tx_serial", 32'(txs_a), 1);
        chk("rst_tx_ready", 32'(ifa.tx_ready), 1);
        chk("rst_tx_active", 32'(act_a), 0);
        chk("rst_tx_done", 32'(done_a), 0);
        chk("rst_rx_data", 32'(ifa.rx_data), 0);
        chk("rst_rx_valid", 32'(ifa.rx_valid), 0);
        chk("rst_frame_err", 32'(ifa.rx_frame_err), 0);
        chk("rst_parity_err", 32'(ifa.rx_parity_err), 0);
        chk("rst_overrun", 32'(ifa.rx_overrun), 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Test 1: 0xA5 over loopback on the 8N1 instance
        ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        wait_start(0, 8);
        tx_bits(0, 32'({1'b1, 8'hA5, 1'b0}), 10, "t1");
        chk("t1_done_pulse", 32'(done_a), 1);
        @(negedge clk);
        chk("t1_done_clear", 32'(done_a), 0);
        chk("t1_ready_back", 32'(ifa.tx_ready), 1);
        chk("t1_done_count", da, 1);
        chk("t1_rx_count", va, 1);
        chk("t1_rx_data", 32'(ifa.rx_data), 32'hA5);
        chk("t1_frame_err", 32'(ifa.rx_frame_err), 0);
        chk("t1_parity_err", 32'(ifa.rx_parity_err), 0);
        chk("t1_overrun", 32'(ifa.rx_overrun), 0);
        ack(0);

        // Test 2: 7O1, 0x55 has four ones so the odd parity bit is 1
        ifb.tx_data = 7'h55; ifb.tx_valid = 1'b1;
        @(negedge clk);
        ifb.tx_valid = 1'b0;
        wait_start(1, 8);
        tx_bits(1, 32'({1'b1, 1'b1, 7'h55, 1'b0}), 10, "t2");
        chk("t2_done_pulse", 32'(done_b), 1);
        chk("t2_rx_count", vb, 1);
        chk("t2_rx_data", 32'(ifb.rx_data), 32'h55);
        chk("t2_parity_err", 32'(ifb.rx_parity_err), 0);
        ack(1);
        lb_b = 1'b0;
        drive_frame(32'({1'b1, 1'b0, 7'h55, 1'b0}), 10);
        chk("t2x_rx_count", vb, 2);
        chk("t2x_rx_data", 32'(ifb.rx_data), 32'h55);
        chk("t2x_parity_err", 32'(ifb.rx_parity_err), 1);
        chk("t2x_frame_err", 32'(ifb.rx_frame_err), 0);
        lb_b = 1'b1;

        // Test 3: external 0x3C with the stop bit low
        lb_a = 1'b0;
        drive_frame(32'({1'b0, 8'h3C, 1'b0}), 10);
        chk("t3_rx_count", va, 2);
        chk("t3_rx_data", 32'(ifa.rx_data), 32'h3C);
        chk("t3_frame_err", 32'(ifa.rx_frame_err), 1);
        chk("t3_parity_err", 32'(ifa.rx_parity_err), 0);

        // Test 4: 3-tick low glitch must be rejected at the mid start sample
        va0 = va;
        rx_line = 1'b0;
        repeat (12) @(negedge clk);
        rx_line = 1'b1;
        repeat (200) @(negedge clk);
        chk("t4_no_valid", va, va0);
        chk("t4_frame_err_kept", 32'(ifa.rx_frame_err), 1);
        chk("t4_data_kept", 32'(ifa.rx_data), 32'h3C);

        // Test 5: overrun on an unacknowledged word
        ack(0);
        drive_frame(32'({1'b1, 8'h11, 1'b0}), 10);
        chk("t5_first_data", 32'(ifa.rx_data), 32'h11);
        chk("t5_first_ovr", 32'(ifa.rx_overrun), 0);
        chk("t5_first_ferr", 32'(ifa.rx_frame_err), 0);
        drive_frame(32'({1'b1, 8'h22, 1'b0}), 10);
        chk("t5_second_data", 32'(ifa.rx_data), 32'h22);
        chk("t5_overrun_set", 32'(ifa.rx_overrun), 1);
        ack(0);
        chk("t5_overrun_clr", 32'(ifa.rx_overrun), 0);

        // Test 6: back-to-back 0xFF then 0x00 with tx_valid held, then reset mid-frame
        lb_a = 1'b1;
        va0 = va;
        ifa.tx_data = 8'hFF; ifa.tx_valid = 1'b1;
        @(negedge clk);
        ifa.tx_data = 8'h00;
        wait_start(0, 8);
        tx_bits(0, 32'({1'b1, 8'hFF, 1'b0}), 10, "t6a");
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        wait_start(0, 8);
        tx_bits(0, 32'({1'b1, 8'h00, 1'b0}), 10, "t6b");
        repeat (100) @(negedge clk);
        chk("t6_idle_ready", 32'(ifa.tx_ready), 1);
        chk("t6_idle_line", 32'(txs_a), 1);
        chk("t6_rx_count", va, va0 + 2);
        chk("t6_rx_data", 32'(ifa.rx_data), 0);
        chk("t6_overrun", 32'(ifa.rx_overrun), 1);
        ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        wait_start(0, 8);
        repeat (3 * 64 + 32) @(negedge clk);
        chk("t6_mid_active", 32'(act_a), 1);
        da0 = da;
        va0 = va;
        reset = 1'b0;
        #1;
        chk("t6_rst_line", 32'(txs_a), 1);
        chk("t6_rst_ready", 32'(ifa.tx_ready), 1);
        chk("t6_rst_active", 32'(act_a), 0);
        chk("t6_rst_rx_data", 32'(ifa.rx_data), 0);
        chk("t6_rst_overrun", 32'(ifa.rx_overrun), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (700) @(negedge clk);
        chk("t6_no_done", da, da0);
        chk("t6_no_rx_valid", va, va0);
        chk("t6_post_line", 32'(txs_a), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_trx_param.md
Name: uart_trx_param

Overview:
Parametrised full-duplex UART transceiver for the board-level UART top. It replaces the separate baud generator, TX module, RX synchroniser and RX module with one block.
- Adds configurable data width, parity and stop bits.
- Adds a valid/ready TX handshake.
- Adds RX framing, parity and overrun error detection.
- Adds an internal loopback mode.
- Sits between the parallel data source/sink (switches, LED controller) and the serial pins.

Parameters:
CLK_DIV, 54, system clocks per 16x oversample tick (>=2); 54 gives 115200 baud at 100 MHz.
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock, single domain
reset  in  1  asynchronous, active-low reset
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data is offered
tx_ready  out  1  TX idle and able to accept a word
tx_serial  out  1  serial output, idles high
tx_active  out  1  high from start bit through last stop bit
tx_done  out  1  one-clock pulse after the last stop bit
rx_serial  in  1  asynchronous serial input
loopback  in  1  1 = RX samples tx_serial internally; rx_serial ignored
rx_data  out  DATA_BITS  last received word, held until the next word
rx_valid  out  1  one-clock pulse when rx_data updates
rx_ack  in  1  consumer has read rx_data; clears rx_pending
rx_frame_err  out  1  stop bit sampled low on the last frame
rx_parity_err  out  1  parity mismatch on the last frame
rx_overrun  out  1  sticky; a new word arrived while rx_pending=1; cleared by rx_ack

Behaviour:
- Reset (reset=0, asynchronous) drives the block to idle:
  - tx_serial=1, tx_ready=1, tx_active=0, tx_done=0.
  - rx_data=0, rx_valid=0, all error flags=0, rx_pending=0.
  - Baud counter=0, both FSMs in IDLE.
  - Synchroniser flops preset to 1.
- Reset mid-frame aborts the frame immediately; no partial rx_valid.
- Baud generator:
  - Counter runs 0..CLK_DIV-1.
  - tick is high for one clk when the count equals CLK_DIV-1.
  - Free-running and shared by TX and RX.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Handshake: a transfer occurs on a clk edge with tx_valid & tx_ready. tx_data is latched and tx_ready drops on the next cycle.
  - The start bit begins at the next tick. Each bit holds for 16 ticks.
  - Data is sent LSB first. The PARITY state exists only when PARITY!=0.
  - Even parity bit = XOR of the data bits; odd parity bit = its inverse.
  - STOP lasts 16*STOP_BITS ticks.
  - tx_done pulses on the clk where STOP ends. tx_ready rises the same cycle.
  - tx_valid held high gives back-to-back frames with no idle gap beyond tick alignment.
  - tx_valid while busy is ignored.
- RX path:
  - rx_serial (or tx_serial when loopback=1) passes through a 2-flop synchroniser.
  - The loopback mux sits ahead of the synchroniser.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a sampled 0 on a tick enters START with the sample counter at 0.
  - START: re-sample at tick 7. If the line is 1, treat it as a glitch and return to IDLE with no flags changed. Otherwise reset the counter.
  - Each following bit is sampled when the counter reaches 15, i.e. at mid-bit.
  - Data is shifted LSB first.
  - Only the first stop bit is checked, even when STOP_BITS=2. The FSM returns to IDLE right after sampling it, so RX re-arms early.
- At the stop sample:
  - rx_data is loaded.
  - rx_frame_err is set to the inverse of the stop sample.
  - rx_parity_err is set to the mismatch result (0 when PARITY=0).
  - rx_valid pulses for one clk.
  - A frame with a framing error still delivers data and the rx_valid pulse.
- Overrun: if rx_pending=1 at the stop sample, rx_overrun is set. The new data still overwrites rx_data.
- Simultaneous rx_ack and a new word: rx_pending stays 1 and rx_overrun is not set.
- Width rules:
  - Bit counter is clog2(DATA_BITS) bits; sample counter is 4 bits; baud counter is clog2(CLK_DIV) bits.
  - No combinational path from any input to any output except none. All outputs are registered.

Decomposition:
- Package uart_pkg:
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state enum ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP, shared by TX and RX.
  - OVERSAMPLE=16 and MID_SAMPLE=7.
- One natural sub-module: uart_baud_tick (CLK_DIV counter producing tick). Instantiate it once.
- TX and RX FSMs stay in the top module.

Test Plan:
- Test 1 (CLK_DIV=4, defaults, loopback=1): send 0xA5. tx_serial carries bits 0,1,0,1,0,0,1,0,1,1, each 64 clks. rx_valid pulses with rx_data=0xA5 and both error flags 0. tx_done follows 640 clks after the start bit.
- Test 2 (PARITY=2, DATA_BITS=7): send 0x55 (four ones). Parity bit is 1. In loopback, rx_data=0x55 and rx_parity_err=0. External frame driving parity 0 gives rx_parity_err=1.
- Test 3 (external rx_serial): drive 0x3C with the stop bit held low. rx_data=0x3C, rx_frame_err=1, rx_valid still pulses.
- Test 4 (glitch): pulse rx_serial low for 3 ticks. No rx_valid, flags unchanged, RX back in IDLE.
- Test 5 (overrun): receive 0x11 with no ack, then 0x22. rx_overrun=1 and rx_data=0x22. rx_ack clears rx_overrun.
- Test 6 (reset and back-to-back): hold tx_valid with 0xFF then 0x00; frames are contiguous and tx_ready is low during each frame. Assert reset mid-DATA: tx_serial=1 and tx_ready=1 immediately, no tx_done.
